// File: rtl/mask_seq_pkg.sv
// Shared types and helpers for the per-frame mask stream sequencer.
package mask_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_BLANK = 3'd1,
        ST_PRE_ONES  = 3'd2,
        ST_PATS      = 3'd3,
        ST_POST_ZERO = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic int unsigned mask_words(input int unsigned rows, input int unsigned wpr);
        return rows * wpr;
    endfunction

    function automatic int unsigned word_cnt_w(input int unsigned mw);
        return $clog2(mw + 1);
    endfunction

    // First enabled phase strictly after cur, in frame order; DONE if none remain.
    function automatic state_t next_phase(input state_t cur, input logic en_blank,
                                          input logic en_ones, input logic en_pats,
                                          input logic en_zero);
        state_t nxt;
        nxt = ST_DONE;
        if (cur == ST_IDLE && en_blank)
            nxt = ST_PRE_BLANK;
        else if ((cur inside {ST_IDLE, ST_PRE_BLANK}) && en_ones)
            nxt = ST_PRE_ONES;
        else if ((cur inside {ST_IDLE, ST_PRE_BLANK, ST_PRE_ONES}) && en_pats)
            nxt = ST_PATS;
        else if ((cur inside {ST_IDLE, ST_PRE_BLANK, ST_PRE_ONES, ST_PATS}) && en_zero)
            nxt = ST_POST_ZERO;
        return nxt;
    endfunction

endpackage

// File: rtl/mask_word_counter.sv
// Word counter for one mask: clear on load, step on enable, wraps to 0 after the terminal word.
module mask_word_counter #(
    parameter int unsigned TERM  = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt;

    assign tc_c = (cnt == CNT_W'(TERM - 1));

    always_ff @(posedge clk) begin
        if (rst || load)
            cnt <= '0;
        else if (en)
            cnt <= tc_c ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/mask_stream_sequencer.sv
// Per-frame mask loader: optional blank, ones mask, num_pat host masks, zeros mask,
// moving words from the host FWFT FIFO to the imager mask FIFO under back-pressure.
module mask_stream_sequencer
    import mask_seq_pkg::*;
#(
    parameter int unsigned DATA_W        = 18,
    parameter int unsigned NUM_ROWS      = 176,
    parameter int unsigned WORDS_PER_ROW = 16,
    parameter int unsigned PAT_CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cam_idle,
    input  logic                 abort,
    input  logic [PAT_CNT_W-1:0] num_pat,
    input  logic                 en_pre_blank,
    input  logic                 en_pre_ones,
    input  logic                 en_post_zero,
    input  logic [DATA_W-1:0]    src_data,
    input  logic                 src_empty,
    output logic                 src_rd_en,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_wr,
    input  logic                 out_full,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          stall_cnt
);

    localparam int unsigned MASK_WORDS = mask_words(NUM_ROWS, WORDS_PER_ROW);
    localparam int unsigned WCNT_W     = word_cnt_w(MASK_WORDS);
    localparam logic [DATA_W-1:0] ONES_WORD = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{1'b0}};

    state_t                 state, state_n;
    logic [PAT_CNT_W-1:0]   num_pat_q, mask_cnt, mask_cnt_n, mask_cnt_inc;
    logic                   pre_blank_q, pre_ones_q, post_zero_q, pats_en;
    logic                   wc_load, wc_en, wc_tc;
    logic                   wr_n, latch_cfg, stall_inc;
    logic [DATA_W-1:0]      data_n;

    assign pats_en      = (num_pat_q != '0);
    assign mask_cnt_inc = mask_cnt + PAT_CNT_W'(1);

    mask_word_counter #(
        .TERM  (MASK_WORDS),
        .CNT_W (WCNT_W)
    ) u_word_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (wc_load),
        .en   (wc_en),
        .tc_c (wc_tc)
    );

    // Next-state, pop and write-request logic; abort overrides every phase.
    always_comb begin
        state_n    = state;
        mask_cnt_n = mask_cnt;
        wc_load    = 1'b0;
        wc_en      = 1'b0;
        src_rd_en  = 1'b0;
        wr_n       = 1'b0;
        data_n     = out_data;
        latch_cfg  = 1'b0;
        stall_inc  = 1'b0;

        if (state != ST_IDLE && abort) begin
            state_n = ST_IDLE;
            wc_load = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && cam_idle) begin
                        latch_cfg  = 1'b1;
                        wc_load    = 1'b1;
                        mask_cnt_n = '0;
                        state_n    = next_phase(ST_IDLE, en_pre_blank, en_pre_ones,
                                                num_pat != '0, en_post_zero);
                    end
                end
                ST_PRE_BLANK: begin
                    wc_en = 1'b1;
                    if (wc_tc)
                        state_n = next_phase(ST_PRE_BLANK, 1'b0, pre_ones_q, pats_en, post_zero_q);
                end
                ST_PRE_ONES: begin
                    if (!out_full) begin
                        wr_n   = 1'b1;
                        data_n = ONES_WORD;
                        wc_en  = 1'b1;
                        if (wc_tc)
                            state_n = next_phase(ST_PRE_ONES, 1'b0, 1'b0, pats_en, post_zero_q);
                    end
                end
                ST_PATS: begin
                    stall_inc = src_empty && !out_full;
                    if (!out_full && !src_empty) begin
                        src_rd_en = 1'b1;
                        wr_n      = 1'b1;
                        data_n    = src_data;
                        wc_en     = 1'b1;
                        // Mask boundary: decide on the incremented count so masks run back to back.
                        if (wc_tc) begin
                            mask_cnt_n = mask_cnt_inc;
                            if (mask_cnt_inc == num_pat_q)
                                state_n = post_zero_q ? ST_POST_ZERO : ST_DONE;
                        end
                    end
                end
                ST_POST_ZERO: begin
                    if (!out_full) begin
                        wr_n   = 1'b1;
                        data_n = ZERO_WORD;
                        wc_en  = 1'b1;
                        if (wc_tc)
                            state_n = ST_DONE;
                    end
                end
                ST_DONE:  state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mask_cnt    <= '0;
            num_pat_q   <= '0;
            pre_blank_q <= 1'b0;
            pre_ones_q  <= 1'b0;
            post_zero_q <= 1'b0;
            out_wr      <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state      <= state_n;
            mask_cnt   <= mask_cnt_n;
            out_wr     <= wr_n;
            out_data   <= data_n;
            busy       <= (state_n != ST_IDLE);
            frame_done <= (state == ST_DONE) && !abort;
            if (latch_cfg) begin
                num_pat_q   <= num_pat;
                pre_blank_q <= en_pre_blank;
                pre_ones_q  <= en_pre_ones;
                post_zero_q <= en_post_zero;
                stall_cnt   <= '0;
            end else if (stall_inc && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Blank enable only steers the IDLE exit; kept latched alongside the other frame options.
    logic unused_cfg;
    assign unused_cfg = pre_blank_q;

endmodule

// File: tb/tb_mask_stream_sequencer.sv
// Self-checking bench: host FIFO model plus expected-word scoreboard built from the frame recipe.
module tb_mask_stream_sequencer;

    localparam int unsigned DATA_W    = 18;
    localparam int unsigned PAT_CNT_W = 32;
    localparam int          MW        = 8;

    logic                 clk = 1'b0;
    logic                 rst, start, cam_idle, abort;
    logic [PAT_CNT_W-1:0] num_pat;
    logic                 en_pre_blank, en_pre_ones, en_post_zero;
    logic [DATA_W-1:0]    src_data;
    logic                 src_empty, src_rd_en;
    logic [DATA_W-1:0]    out_data;
    logic                 out_wr, out_full, busy, frame_done;
    logic [15:0]          stall_cnt;

    mask_stream_sequencer #(
        .DATA_W(DATA_W), .NUM_ROWS(4), .WORDS_PER_ROW(2), .PAT_CNT_W(PAT_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cam_idle(cam_idle), .abort(abort),
        .num_pat(num_pat), .en_pre_blank(en_pre_blank), .en_pre_ones(en_pre_ones),
        .en_post_zero(en_post_zero), .src_data(src_data), .src_empty(src_empty),
        .src_rd_en(src_rd_en), .out_data(out_data), .out_wr(out_wr), .out_full(out_full),
        .busy(busy), .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Host FIFO model: preloaded words, read pointer advances on each pop.
    logic [DATA_W-1:0] src_mem [0:511];
    int                src_avail  = 0;
    int                rd_ptr     = 0;
    logic              hold_empty = 1'b0;

    assign src_empty = hold_empty || (rd_ptr >= src_avail);
    assign src_data  = src_mem[9'(rd_ptr)];

    logic [DATA_W-1:0] exp_q[$];
    int   n_wr = 0, n_fd = 0, first_wr_cyc = -1, cyc = 0;
    logic prev_full = 1'b0;

    always @(posedge clk) begin
        cyc++;
        prev_full <= out_full;
        if (!rst && src_rd_en) begin
            check("pop_when_empty", src_empty, 0);
            check("pop_when_full", out_full, 0);
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_wr) begin
                n_wr++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                check("write_after_full", prev_full, 0);
                if (exp_q.size() == 0) check("unexpected_write", out_wr, 0);
                else check("write_data", out_data, exp_q.pop_front());
            end
            if (frame_done) n_fd++;
        end
    end

    // kind: 0 none, 1 out_full x5, 2 src_empty x7, 3 abort, 4 start while busy.
    task automatic run_frame(input int np, input bit blk, input bit ones, input bit zero,
                             input bit rnd, input int trig_wr, input int kind, input int exp_stall);
        int base, wr0, fd0, total, start_cyc, full_left, empty_left;
        bit fired, aborted, finished;
        base = rd_ptr;
        while (src_avail < base + np * MW) begin
            src_mem[9'(src_avail)] = DATA_W'($urandom);
            src_avail++;
        end
        exp_q.delete();
        if (ones) repeat (MW) exp_q.push_back({DATA_W{1'b1}});
        for (int i = 0; i < np * MW; i++) exp_q.push_back(src_mem[9'(base + i)]);
        if (zero) repeat (MW) exp_q.push_back({DATA_W{1'b0}});
        total = exp_q.size();
        wr0 = n_wr; fd0 = n_fd; first_wr_cyc = -1;
        num_pat = PAT_CNT_W'(np); en_pre_blank = blk; en_pre_ones = ones; en_post_zero = zero;
        start = 1'b1; cam_idle = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; start_cyc = cyc;
        fired = 0; aborted = 0; finished = 0; full_left = 0; empty_left = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (!fired && kind != 0 && (n_wr - wr0) == trig_wr) begin
                fired = 1;
                case (kind)
                    1: full_left = 5;
                    2: empty_left = 7;
                    3: abort = 1'b1;
                    default: start = 1'b1;
                endcase
            end
            out_full   = (full_left > 0) || (rnd && $urandom_range(0, 3) == 0);
            hold_empty = (empty_left > 0) || (rnd && $urandom_range(0, 4) == 0);
            if (full_left > 0) full_left--;
            if (empty_left > 0) empty_left--;
            @(negedge clk); #1;
            if (abort) begin
                abort = 1'b0; aborted = 1; finished = 1;
                check("abort_idle", busy, 0);
                check("abort_no_write", out_wr, 0);
                check("abort_writes", n_wr - wr0, trig_wr);
                check("abort_pops", rd_ptr - base, trig_wr - (ones ? MW : 0));
                check("abort_no_done", n_fd - fd0, 0);
            end
            if (start) begin
                start = 1'b0;
                check("start_while_busy", busy, 1);
            end
            if (n_fd != fd0) finished = 1;
        end
        out_full = 1'b0; hold_empty = 1'b0;
        if (!aborted) begin
            check("frame_timeout", finished, 1);
            check("frame_writes", n_wr - wr0, total);
            check("frame_pops", rd_ptr - base, np * MW);
            check("missing_words", exp_q.size(), 0);
            @(negedge clk); #1;
            check("frame_done_once", n_fd - fd0, 1);
            check("idle_after_done", busy, 0);
            if (exp_stall >= 0) check("stall_cnt", stall_cnt, exp_stall);
            if (!rnd && total > 0) check("first_write_delay", first_wr_cyc - start_cyc, 1 + (blk ? MW : 0));
        end
        exp_q.delete();
    endtask

    initial begin
        int wr0;
        rst = 1'b1; start = 1'b0; cam_idle = 1'b1; abort = 1'b0; num_pat = '0;
        en_pre_blank = 1'b0; en_pre_ones = 1'b0; en_post_zero = 1'b0; out_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_wr", out_wr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_src_rd_en", src_rd_en, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        run_frame(2, 1, 1, 1, 0, -1, 0, 0);   // full recipe, 32 writes
        run_frame(0, 0, 1, 0, 0, -1, 0, 0);   // ones only, no pops
        run_frame(2, 0, 1, 1, 0, 11, 1, 0);   // out_full stall after 3rd word of a mask
        run_frame(1, 0, 1, 0, 0, 11, 2, 7);   // host empty for 7 cycles mid-PATS
        run_frame(2, 0, 1, 1, 0, 11, 3, -1);  // abort after 3rd PATS word
        run_frame(2, 0, 1, 1, 0, -1, 0, 0);   // fresh frame restarts at ones phase
        run_frame(1, 1, 0, 1, 0, 4, 4, 0);    // start pulse while busy is ignored

        // start with camera not idle is ignored
        wr0 = n_wr;
        start = 1'b1; cam_idle = 1'b0;
        @(negedge clk); #1;
        start = 1'b0; cam_idle = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("cam_busy_start_ignored", busy, 0);
        check("cam_busy_no_writes", n_wr - wr0, 0);

        for (int k = 0; k < 8; k++)
            run_frame($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
